// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: fetch PC, preloadable word memory with a one-cycle
// synchronous read, and a registered valid/ready output beat for decode.
// Supports redirect/flush and halts on a misaligned or out-of-window fetch.
module ysyx_23060096_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_fault,
    output logic [31:0]              fetch_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] mem [DEPTH];

    logic          slot_free;
    logic          do_fetch;
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_off;
    logic          fetch_legal;
    logic [AW-1:0] fetch_idx;

    // Select the fetch address, check it against the window and decide whether
    // a fetch is issued this cycle; a redirect fetches regardless of out_ready.
    always_comb begin
        slot_free   = !out_valid || out_ready;
        fetch_addr  = redirect_valid ? redirect_pc : pc_q;
        fetch_off   = fetch_addr - RESET_PC;
        fetch_legal = (fetch_addr[1:0] == 2'b00) && ((fetch_off >> (AW + 2)) == 32'd0);
        fetch_idx   = fetch_off[AW+1:2];
        if (redirect_valid) begin
            do_fetch = fetch_en;
        end else begin
            do_fetch = (state == RUN) && fetch_en && slot_free;
        end
    end

    // Load port writes; memory contents survive reset and loads are blocked in reset.
    always_ff @(posedge clk) begin
        if (rst_n && load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    // Fetch FSM, PC, output beat register and accepted-beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            pc_q      <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
            out_fault <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (out_valid && out_ready) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                state <= RUN;
            end
            if (do_fetch) begin
                out_valid <= 1'b1;
                out_pc    <= fetch_addr;
                if (fetch_legal) begin
                    // Non-blocking read of mem gives read-before-write against the load port.
                    out_inst  <= mem[fetch_idx];
                    out_fault <= 1'b0;
                    pc_q      <= fetch_addr + 32'd4;
                end else begin
                    out_inst  <= '0;
                    out_fault <= 1'b1;
                    pc_q      <= fetch_addr;
                    state     <= HALT;
                end
            end else if (redirect_valid) begin
                out_valid <= 1'b0;
                pc_q      <= redirect_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Directed testbench for ysyx_23060096_ifu with a 16-word memory window.
module tb_ysyx_23060096_ifu;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        load_en;
    logic [3:0]  load_idx;
    logic [31:0] load_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic [31:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] img [DEPTH];

    ysyx_23060096_ifu #(
        .RESET_PC(32'h8000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .load_en       (load_en),
        .load_idx      (load_idx),
        .load_data     (load_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_fault     (out_fault),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic fault);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".pc"},    out_pc, pc);
        chk({tag, ".inst"},  out_inst, inst);
        chk({tag, ".fault"}, {31'd0, out_fault}, {31'd0, fault});
    endtask

    initial begin
        img[0] = 32'h00F0_0093;
        img[1] = 32'h00F0_0193;
        img[2] = 32'h0000_0013;
        img[3] = 32'h0010_0073;
        for (int i = 4; i < DEPTH; i++) img[i] = 32'h1000_0000 + i;

        rst_n = 1'b0; fetch_en = 1'b0; load_en = 1'b0; load_idx = '0; load_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.pc",    out_pc, 32'd0);
        chk("rst.inst",  out_inst, 32'd0);
        chk("rst.fault", {31'd0, out_fault}, 32'd0);
        chk("rst.cnt",   fetch_cnt, 32'd0);

        // Preload with fetch disabled
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1; load_idx = i[3:0]; load_data = img[i];
            tick();
        end
        load_en = 1'b0;
        chk("load.novalid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;

        // Linear run
        tick(); beat("run0", 32'h8000_0000, img[0], 1'b0); chk("run0.cnt", fetch_cnt, 32'd0);
        tick(); beat("run1", 32'h8000_0004, img[1], 1'b0); chk("run1.cnt", fetch_cnt, 32'd1);
        tick(); beat("run2", 32'h8000_0008, img[2], 1'b0);
        tick(); beat("run3", 32'h8000_000C, img[3], 1'b0); chk("run3.cnt", fetch_cnt, 32'd3);
        fetch_en = 1'b0;
        tick();
        chk("idle.valid", {31'd0, out_valid}, 32'd0);
        chk("run.cnt4", fetch_cnt, 32'd4);

        // Backpressure on 0x80000004
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0004; fetch_en = 1'b1;
        tick(); beat("bp.first", 32'h8000_0004, img[1], 1'b0);
        redirect_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); beat("bp.hold", 32'h8000_0004, img[1], 1'b0);
            chk("bp.cnt", fetch_cnt, 32'd4);
        end
        out_ready = 1'b1;
        tick(); beat("bp.next", 32'h8000_0008, img[2], 1'b0); chk("bp.cnt5", fetch_cnt, 32'd5);

        // Redirect while stalled
        out_ready = 1'b0;
        tick(); beat("rs.stall", 32'h8000_0008, img[2], 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_000C;
        tick(); beat("rs.beat", 32'h8000_000C, 32'h0010_0073, 1'b0);
        chk("rs.cnt", fetch_cnt, 32'd5);
        redirect_valid = 1'b0; out_ready = 1'b1;
        tick(); beat("rs.next", 32'h8000_0010, img[4], 1'b0); chk("rs.cnt6", fetch_cnt, 32'd6);

        // Misaligned fault and halt
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        tick(); beat("mis", 32'h8000_0002, 32'd0, 1'b1); chk("mis.cnt", fetch_cnt, 32'd7);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); chk("halt.valid", {31'd0, out_valid}, 32'd0);
        end
        chk("halt.cnt", fetch_cnt, 32'd8);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        tick(); beat("resume0", 32'h8000_0000, img[0], 1'b0);
        redirect_valid = 1'b0;
        tick(); beat("resume1", 32'h8000_0004, img[1], 1'b0);

        // Window upper bound
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0038;
        tick(); beat("win38", 32'h8000_0038, img[14], 1'b0);
        redirect_valid = 1'b0;
        tick(); beat("win3c", 32'h8000_003C, img[15], 1'b0);
        tick(); beat("win40", 32'h8000_0040, 32'd0, 1'b1);
        tick(); chk("win.halt1", {31'd0, out_valid}, 32'd0);
        tick(); chk("win.halt2", {31'd0, out_valid}, 32'd0);

        // Below the window
        redirect_valid = 1'b1; redirect_pc = 32'h7FFF_FFFC;
        tick(); beat("below", 32'h7FFF_FFFC, 32'd0, 1'b1);
        redirect_valid = 1'b0;
        tick(); chk("below.halt", {31'd0, out_valid}, 32'd0);

        // Same-cycle load and fetch of index 1
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        tick(); beat("rbw0", 32'h8000_0000, img[0], 1'b0);
        redirect_valid = 1'b0;
        load_en = 1'b1; load_idx = 4'd1; load_data = 32'hCAFE_BABE;
        tick(); beat("rbw.old", 32'h8000_0004, img[1], 1'b0);
        load_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0004;
        tick(); beat("rbw.new", 32'h8000_0004, 32'hCAFE_BABE, 1'b0);
        redirect_valid = 1'b0;

        // Reset mid-stream; a load during reset must be ignored
        chk("mid.valid_pre", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0; load_en = 1'b1; load_idx = 4'd2; load_data = 32'hDEAD_BEEF;
        tick();
        chk("mid.valid", {31'd0, out_valid}, 32'd0);
        chk("mid.cnt", fetch_cnt, 32'd0);
        rst_n = 1'b1; load_en = 1'b0;
        tick(); beat("post0", 32'h8000_0000, img[0], 1'b0);
        tick(); beat("post1", 32'h8000_0004, 32'hCAFE_BABE, 1'b0);
        tick(); beat("post2", 32'h8000_0008, img[2], 1'b0);
        chk("post.cnt", fetch_cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_ifu.md
# ysyx_23060096_ifu

Parametrised instruction fetch unit for the single-issue RV32 core. It owns the fetch PC register and a word-addressed instruction memory with a synchronous read, backed by a load port for image preload. It delivers one instruction per cycle to decode over a valid/ready handshake, with branch/jump redirect, flush, and fault reporting. It replaces the fixed two-instruction PC/ROM block.

## Interface
- RESET_PC, default 32'h8000_0000: first fetch address after reset; base of the memory window.
- DEPTH, default 256: memory size in 32-bit words. Must be a power of two, ≥2. AW = $clog2(DEPTH) is a localparam.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fetch_en  in  1  permits new fetches. When low, no fetch is issued and pc_q holds.
- load_en  in  1  memory write strobe.
- load_idx  in  AW  word index to write.
- load_data  in  32  instruction word to write.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- out_valid  out  1  out_pc/out_inst/out_fault hold a beat for decode.
- out_ready  in  1  decode accepts the beat this cycle.
- out_pc  out  32  address of the beat.
- out_inst  out  32  instruction word; 0 on fault.
- out_fault  out  1  beat is a fetch fault: misaligned or out of window.
- fetch_cnt  out  32  count of accepted beats (out_valid && out_ready); wraps mod 2^32.

## Operation
- Internal state:
  - pc_q, the next fetch address.
  - The output register (out_*).
  - A two-state FSM, RUN and HALT.
  - fetch_cnt.
  - mem[DEPTH], 32 bits wide.
- Reset values: pc_q = RESET_PC, out_valid = 0, out_pc = 0, out_inst = 0, out_fault = 0, fetch_cnt = 0, FSM = RUN.
  - mem is not cleared by reset.
  - load_en is ignored while rst_n = 0.
- Address check for a fetch address A:
  - off = A − RESET_PC, computed as a 32-bit wraparound subtraction.
  - A is legal iff A[1:0] == 0 and off[31:AW+2] == 0.
  - The memory index is off[AW+1:2].
- slot_free = !out_valid || out_ready.
- Cycle priority, highest first:
  1. Reset.
  2. Redirect: the output register is flushed (out_valid ← 0) and FSM ← RUN.
     - If fetch_en is high, a fetch of redirect_pc is issued this same cycle, regardless of out_ready.
     - If fetch_en is low, pc_q ← redirect_pc.
  3. Normal fetch: requires FSM = RUN, fetch_en = 1 and slot_free. It fetches from pc_q.
  4. Otherwise, if out_ready is high, out_valid ← 0.
- Issuing a fetch from address A:
  - out_valid ← 1 and out_pc ← A.
  - Legal A: out_inst ← mem[idx], out_fault ← 0, pc_q ← A + 4 (32-bit wrap).
  - Illegal A: out_inst ← 0, out_fault ← 1, pc_q ← A, FSM ← HALT.
- HALT issues no fetches. The fault beat is still delivered normally. Only a redirect or reset leaves HALT.
- fetch_cnt increments on every cycle with out_valid && out_ready, including a cycle that also carries a redirect. A beat flushed while stalled is not counted.
- Load port: on load_en, mem[load_idx] ← load_data. A fetch of the same index in the same cycle returns the old word (read-before-write).

## Timing
- Read latency is one cycle: a fetch issued in cycle t appears on out_* in t+1.
- Throughput is one beat per cycle while out_ready = 1.
- The first beat after reset is out_pc = RESET_PC, valid one cycle after the first cycle with rst_n = 1 and fetch_en = 1.
- Backpressure: while out_valid && !out_ready, all out_* signals and pc_q are stable. No beat is skipped or duplicated.
- Redirect at cycle t with fetch_en = 1: the cycle t+1 beat is redirect_pc, and the stalled beat is discarded.
- Redirect and fetch_en deasserted together: out_valid = 0 from t+1.
- Reset mid-stream: out_valid = 0 in the next cycle, and fetching restarts at RESET_PC.

## Test plan
- Preload, then run: load mem[0..3] = 0x00F00093, 0x00F00193, 0x00000013, 0x00100073, then apply reset and fetch_en = 1 with out_ready = 1.
  - Required: on four consecutive cycles, out_pc = 0x80000000/04/08/0C with the matching words.
  - Required: fetch_cnt = 4 afterwards.
- Backpressure: drop out_ready for 3 cycles while out_pc = 0x80000004.
  - Required: out_pc/out_inst held for all 3 cycles, then 0x80000008 follows with no gap or duplicate.
  - Required: fetch_cnt is frozen during the stall.
- Redirect while stalled: pulse redirect_valid with redirect_pc = 0x8000000C while out_valid && !out_ready.
  - Required: next cycle out_pc = 0x8000000C, out_inst = 0x00100073.
  - Required: the flushed beat is not counted.
- Misaligned fault: redirect to 0x80000002.
  - Required: beat shows out_fault = 1, out_inst = 0, out_pc = 0x80000002, then no further valid beats for 10 cycles.
  - Then redirect to 0x80000000. Required: normal stream resumes.
- Window bound with DEPTH = 16: run linearly.
  - Required: 0x8000003C is fetched normally; 0x80000040 produces a fault beat and HALT.
  - Also redirect to 0x7FFFFFFC. Required: fault beat.
- Same-cycle load and fetch: write mem[1] in the cycle 0x80000004 is fetched.
  - Required: the old word is returned; a refetch after redirect returns the new word.
- Reset mid-operation: assert rst_n = 0 with out_valid = 1.
  - Required: next cycle out_valid = 0 and fetch_cnt = 0.
  - Required: after release, the first beat is 0x80000000 with preloaded contents intact.
